// File: rtl/selector_config_pkg.sv
// selector_config_pkg
//   Shared definitions for the selector_config slice: the debounce FSM
//   state encoding, default parameter values and the saturating
//   up/down step used for the bf/bc selection registers.
package selector_config_pkg;

  // Debounce FSM states, one FSM per push-button.
  typedef enum logic [1:0] {
    DEB_RELEASED     = 2'd0,
    DEB_PRESS_WAIT   = 2'd1,
    DEB_PRESSED      = 2'd2,
    DEB_RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam int         DEB_CYCLES_DEF = 500000;
  localparam logic [3:0] MAX_BF_DEF     = 4'd9;
  localparam logic [3:0] MAX_BC_DEF     = 4'd9;

  // One saturating step: +1 up to maxv, -1 down to 0. Simultaneous
  // up and down cancel, so the value is left unchanged.
  function automatic logic [3:0] sat_step(input logic [3:0] v,
                                          input logic       up,
                                          input logic       dn,
                                          input logic [3:0] maxv);
    logic [3:0] r;
    r = v;
    if (up && !dn) begin
      if (v < maxv) r = v + 4'd1;
    end else if (dn && !up) begin
      if (v != 4'd0) r = v - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/selector_config_debounce_pulse.sv
// debounce_pulse
//   Two-flop synchronizer, four-state debounce FSM and a registered
//   one-cycle pulse emitted only when a press is accepted.
//   Ports:
//     clk    - system clock
//     rst_n  - asynchronous active-low reset
//     btn    - raw, bouncing push-button level
//     pulse  - one-cycle pulse per accepted press
module debounce_pulse
  import selector_config_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  // Counter runs 0..DEB_CYCLES-1 and is cleared on every exit from a
  // WAIT state, so it can never wrap.
  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          synced;
  deb_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          pulse_reg, pulse_next;

  assign synced = sync_reg[1];
  assign pulse  = pulse_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b00;
      state_reg <= DEB_RELEASED;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
    end
  end

  // Next-state logic. The sample that moves RELEASED->PRESS_WAIT is
  // not counted; DEB_CYCLES further stable samples are then required.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      DEB_RELEASED: begin
        if (synced) state_next = DEB_PRESS_WAIT;
      end
      DEB_PRESS_WAIT: begin
        if (!synced)                 state_next = DEB_RELEASED;
        else if (cnt_reg == CNT_LAST) state_next = DEB_PRESSED;
        else                         cnt_next   = cnt_reg + 1'b1;
      end
      DEB_PRESSED: begin
        if (!synced) state_next = DEB_RELEASE_WAIT;
      end
      DEB_RELEASE_WAIT: begin
        if (synced)                  state_next = DEB_PRESSED;
        else if (cnt_reg == CNT_LAST) state_next = DEB_RELEASED;
        else                         cnt_next   = cnt_reg + 1'b1;
      end
      default: state_next = DEB_RELEASED;
    endcase
  end

  // Output logic: pulse only on the accepted PRESS_WAIT->PRESSED move.
  always_comb begin
    pulse_next = (state_reg == DEB_PRESS_WAIT) && synced && (cnt_reg == CNT_LAST);
  end

endmodule

// File: rtl/selector_config.sv
// selector_config
//   Three debounced push-buttons adjust two saturating 4-bit indices
//   (frequency bf, current bc); btn_mode chooses which one is edited.
//   Ports:
//     clk       - system clock
//     rst_n     - asynchronous active-low reset (clean deassert assumed)
//     btn_up    - raw increment button
//     btn_down  - raw decrement button
//     btn_mode  - raw selection toggle button
//     opcion    - 0: bf selected, 1: bc selected
//     bf, bc    - registered selection indices
module selector_config
  import selector_config_pkg::*;
#(
  parameter int         DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic [3:0] MAX_BF     = MAX_BF_DEF,
  parameter logic [3:0] MAX_BC     = MAX_BC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mode,
  output logic       opcion,
  output logic [3:0] bf,
  output logic [3:0] bc
);

  // Index 0 = up, 1 = down, 2 = mode
  logic [2:0] btn_vec;
  logic [2:0] pulse_vec;

  assign btn_vec = {btn_mode, btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      debounce_pulse #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_vec[gi]),
        .pulse(pulse_vec[gi])
      );
    end
  endgenerate

  logic       opcion_reg, opcion_next;
  logic [3:0] bf_reg, bf_next;
  logic [3:0] bc_reg, bc_next;

  // Up/down act on the register chosen by the current opcion, i.e. the
  // selection before any simultaneous mode toggle takes effect.
  always_comb begin
    bf_next     = bf_reg;
    bc_next     = bc_reg;
    opcion_next = opcion_reg ^ pulse_vec[2];
    if (!opcion_reg) bf_next = sat_step(bf_reg, pulse_vec[0], pulse_vec[1], MAX_BF);
    else             bc_next = sat_step(bc_reg, pulse_vec[0], pulse_vec[1], MAX_BC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcion_reg <= 1'b0;
      bf_reg     <= 4'd0;
      bc_reg     <= 4'd0;
    end else begin
      opcion_reg <= opcion_next;
      bf_reg     <= bf_next;
      bc_reg     <= bc_next;
    end
  end

  assign opcion = opcion_reg;
  assign bf     = bf_reg;
  assign bc     = bc_reg;

endmodule

// File: tb/tb_selector_config.sv
module tb_selector_config;

  localparam int DEB = 4;
  localparam int LAT = DEB + 4;
  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_mode = 1'b0;
  logic       opcion;
  logic [3:0] bf;
  logic [3:0] bc;

  always #5 clk = ~clk;

  selector_config #(
    .DEB_CYCLES(DEB),
    .MAX_BF    (4'd9),
    .MAX_BC    (4'd9)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_mode(btn_mode),
    .opcion  (opcion),
    .bf      (bf),
    .bc      (bc)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what a user of the selector expects to see.
  int m_bf = 0;
  int m_bc = 0;
  int m_op = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " bf"}, {28'd0, bf}, m_bf);
    check({tag, " bc"}, {28'd0, bc}, m_bc);
    check({tag, " opcion"}, {31'd0, opcion}, m_op);
  endtask

  // Effect of one accepted press of the given button combination.
  task automatic model_press(input bit u, input bit d, input bit m);
    int sel;
    sel = (m_op == 0) ? m_bf : m_bc;
    if (u && !d)      sel = (sel < MAXV) ? sel + 1 : MAXV;
    else if (d && !u) sel = (sel > 0) ? sel - 1 : 0;
    if (m_op == 0) m_bf = sel; else m_bc = sel;
    if (m) m_op = 1 - m_op;
  endtask

  task automatic drive(input bit u, input bit d, input bit m);
    btn_up = u; btn_down = d; btn_mode = m;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press a button combination (optionally with bounce glitches before
  // the stable level), verify the update lands exactly LAT cycles after
  // the last rising edge, then release and verify no further change.
  task automatic press(input string tag, input bit u, input bit d, input bit m,
                       input bit bounce, input int hold);
    @(negedge clk);
    if (bounce) begin
      drive(u, d, m); cycles(2);
      drive(0, 0, 0); cycles(1);
      drive(u, d, m); cycles(1);
      drive(0, 0, 0); cycles(2);
    end
    drive(u, d, m);
    cycles(LAT - 1);
    check_all({tag, " pre"});
    cycles(1);
    model_press(u, d, m);
    check_all({tag, " upd"});
    cycles(hold - LAT);
    drive(0, 0, 0);
    cycles(12);
    check_all({tag, " held"});
    $display("press %s up=%0d dn=%0d md=%0d bounce=%0d -> bf=%0d bc=%0d opcion=%0d",
             tag, u, d, m, bounce, bf, bc, opcion);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cycles(3);
    check_all("reset");
    rst_n = 1'b1;
    cycles(3);
    check_all("post_reset");

    // Clean press, held 10 cycles: single increment
    press("up_clean", 1, 0, 0, 0, 10);
    // Bouncing press: one increment timed from last rising edge
    press("up_bounce", 1, 0, 0, 1, 10);
    // Saturation at MAX_BF
    for (int i = 0; i < 8; i++) press("up_sat", 1, 0, 0, 0, 9);
    // Mode to current selection, down from 0 stays 0
    press("mode1", 0, 0, 1, 0, 9);
    press("dn_floor", 0, 1, 0, 0, 9);
    press("up_bc", 1, 0, 0, 0, 9);
    press("up_bc", 1, 0, 0, 0, 9);
    press("mode0", 0, 0, 1, 0, 9);
    // Down on bf from 9, then simultaneous up+down, then mode+up
    press("dn_bf", 0, 1, 0, 0, 9);
    press("up_dn", 1, 1, 0, 0, 9);
    press("mode_up", 1, 0, 1, 0, 9);

    // Reset in the middle of a press-wait; button held through reset
    @(negedge clk);
    drive(1, 0, 0);
    cycles(5);
    rst_n = 1'b0;
    #1;
    m_bf = 0; m_bc = 0; m_op = 0;
    check_all("rst_mid");
    cycles(3);
    check_all("rst_hold");
    rst_n = 1'b1;
    cycles(LAT - 1);
    check_all("rst_rel pre");
    cycles(1);
    model_press(1, 0, 0);
    check_all("rst_rel upd");
    cycles(4);
    drive(0, 0, 0);
    cycles(12);
    check_all("rst_rel held");
    $display("press rst_mid up=1 -> bf=%0d bc=%0d opcion=%0d", bf, bc, opcion);

    // Randomized presses against the model
    for (int i = 0; i < 30; i++) begin
      bit u, d, m, b;
      int h;
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 3) == 0);
      if (!u && !d && !m) u = 1'b1;
      b = 1'($urandom_range(0, 1));
      h = int'($urandom_range(LAT, LAT + 4));
      press("rand", u, d, m, b, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/selector_config.md
SELECTOR_CONFIG -- requirements
Module: selector_config

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, consecutive stable cycles required to accept a button level change (minimum 2).
REQ-002 Parameter MAX_BF, default 4'd9, upper saturation limit of bf.
REQ-003 Parameter MAX_BC, default 4'd9, upper saturation limit of bc.
REQ-004 clk  input  1  single system clock; all state SHALL be on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn_up  input  1  raw push-button (asynchronous, bouncing), increment.
REQ-007 btn_down  input  1  raw push-button, decrement.
REQ-008 btn_mode  input  1  raw push-button, toggle between frequency and current selection.
REQ-009 opcion  output  1  0 = frequency value selected, 1 = current value selected; feeds the display stage.
REQ-010 bf  output  4  selected frequency constant index, registered.
REQ-011 bc  output  4  selected current constant index, registered.

Function
REQ-012 Each button input SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each button SHALL have its own debounce FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 RELEASED -> PRESS_WAIT when synced=1; PRESS_WAIT -> PRESSED after DEB_CYCLES consecutive synced=1 samples; PRESS_WAIT -> RELEASED on any synced=0 (counter cleared).
REQ-015 PRESSED -> RELEASE_WAIT when synced=0; RELEASE_WAIT -> RELEASED after DEB_CYCLES consecutive synced=0 samples; RELEASE_WAIT -> PRESSED on any synced=1.
REQ-016 The PRESS_WAIT -> PRESSED transition SHALL generate exactly one registered one-cycle pulse; no other transition generates a pulse (a held button yields one pulse only).
REQ-017 Latency from a clean raw rising edge to the updated bf/bc/opcion value SHALL be exactly DEB_CYCLES+4 clk cycles.
REQ-018 Up pulse: when opcion=0, bf <= bf+1 saturating at MAX_BF; when opcion=1, bc <= bc+1 saturating at MAX_BC.
REQ-019 Down pulse: decrements the selected register, saturating at 0; no wrap-around in either direction.
REQ-020 Up and down pulses in the same cycle SHALL leave bf and bc unchanged.
REQ-021 Mode pulse SHALL toggle opcion; a simultaneous up/down pulse applies to the register selected by opcion before the toggle.
REQ-022 The unselected register SHALL hold its value indefinitely.
REQ-023 Debounce counters SHALL be wide enough for DEB_CYCLES and SHALL not wrap while in a WAIT state.

Reset
REQ-024 On rst_n=0 (asynchronous): opcion=0, bf=0, bc=0, all FSMs RELEASED, counters 0, synchronizers 0, pulses 0.
REQ-025 Reset asserted mid-debounce SHALL discard the pending press; after release a button held through reset SHALL produce one pulse DEB_CYCLES+4 cycles later.
REQ-026 Reset deassertion SHALL be taken synchronously into the clk domain by the parent; this block assumes a clean deassert edge.

Structure
REQ-027 Shared package SHALL hold the debounce FSM state encoding and default values of DEB_CYCLES, MAX_BF, MAX_BC.
REQ-028 One sub-module debounce_pulse (synchronizer + FSM + pulse) SHALL be instantiated three times; selector_config holds opcion, bf, bc logic.

Verification (DEB_CYCLES=4, MAX_BF=MAX_BC=9)
REQ-029 Reset, press btn_up clean for 10 cycles -> bf 0->1 exactly 8 cycles after press, held press gives no second increment.
REQ-030 btn_up with 3-cycle bounce glitches (1,0,1 each <4 cycles) then stable high -> exactly one increment, timed from last rising edge.
REQ-031 Ten up presses from bf=0 -> bf=9 after ninth, tenth leaves 9; one down press from bc=0 -> bc stays 0.
REQ-032 btn_mode press -> opcion=1; then two up presses -> bc=2, bf unchanged; mode again -> opcion=0.
REQ-033 btn_up and btn_down pressed on the same cycle -> no change; btn_mode and btn_up same cycle with opcion=0 -> bf+1 and opcion=1.
REQ-034 rst_n pulsed low while btn_up in PRESS_WAIT -> outputs 0, no increment from that press; button still held after release -> single increment 8 cycles later.
